eth_rx_framer: RTL and testbench



---
 rtl/eth_rx_framer_if.sv | 11 +
 rtl/eth_rx_framer.sv | 150 +++++++++++++++
 tb/tb_eth_rx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_framer_if.sv
// Payload stream from the receive framer to the MAC: byte, valid, end-of-frame and frame-bad flag.
// No ready signal exists because the PHY side cannot be stalled.
interface eth_rx_framer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_err;

    modport master (output m_data, output m_valid, output m_last, output m_err);
    modport slave  (input  m_data, input  m_valid, input  m_last, input  m_err);
endinterface

// File: rtl/eth_rx_framer.sv
// Receive framer: strips preamble/SFD, checks and strips the FCS, and streams the payload to the MAC.
// Also keeps good and bad frame counters.
module eth_rx_framer #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_dv,
    input  logic                 rx_er,
    input  logic [7:0]           rxd,
    eth_rx_framer_if.master      mac,
    output logic [CNT_WIDTH-1:0] frame_ok_cnt,
    output logic [CNT_WIDTH-1:0] frame_err_cnt
);

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_LEN       = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN       = 11'(MAX_FRAME);
    localparam logic [10:0] LEN_SAT       = 11'h7FF;
    localparam logic [10:0] DLY_DEPTH     = 11'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Reflected CRC-32, one byte LSB-first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_r;
    logic [31:0] crc_r;
    logic [10:0] cnt_r;
    logic        err_r;
    logic [7:0]  dly_r [5];

    logic [31:0] crc_next_s;
    logic [10:0] cnt_next_s;
    logic        frame_bad_s;
    logic        dly_full_s;

    // Next CRC/length and end-of-frame verdict; the CRC already covers every byte incl. FCS at rx_dv low.
    always_comb begin
        crc_next_s  = crc32_byte(crc_r, rxd);
        cnt_next_s  = (cnt_r == LEN_SAT) ? cnt_r : (cnt_r + 11'd1);
        dly_full_s  = (cnt_r >= DLY_DEPTH);
        frame_bad_s = err_r || (crc_r != CRC_RESIDUE) || (cnt_r < MIN_LEN) || (cnt_r > MAX_LEN);
    end

    // Frame state machine with registered stream outputs and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            crc_r         <= CRC_INIT;
            cnt_r         <= 11'd0;
            err_r         <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                dly_r[i] <= 8'h00;
            end
            mac.m_data    <= 8'h00;
            mac.m_valid   <= 1'b0;
            mac.m_last    <= 1'b0;
            mac.m_err     <= 1'b0;
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            mac.m_valid <= 1'b0;
            mac.m_last  <= 1'b0;
            mac.m_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_dv) begin
                        state_r <= (rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        state_r <= ST_IDLE;
                    end else if (rxd == SFD_BYTE) begin
                        state_r <= ST_DATA;
                        crc_r   <= CRC_INIT;
                        cnt_r   <= 11'd0;
                        err_r   <= 1'b0;
                        for (int i = 0; i < 5; i++) begin
                            dly_r[i] <= 8'h00;
                        end
                    end else if (rxd != PREAMBLE_BYTE) begin
                        state_r <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (rx_dv) begin
                        crc_r    <= crc_next_s;
                        cnt_r    <= cnt_next_s;
                        dly_r[0] <= rxd;
                        for (int i = 1; i < 5; i++) begin
                            dly_r[i] <= dly_r[i-1];
                        end
                        if (rx_er) begin
                            err_r <= 1'b1;
                        end
                        if (dly_full_s) begin
                            mac.m_data  <= dly_r[4];
                            mac.m_valid <= 1'b1;
                        end
                    end else begin
                        // The four youngest bytes in the delay line are the FCS and are dropped.
                        state_r <= ST_IDLE;
                        if (dly_full_s) begin
                            mac.m_data  <= dly_r[4];
                            mac.m_valid <= 1'b1;
                            mac.m_last  <= 1'b1;
                            mac.m_err   <= frame_bad_s;
                            if (frame_bad_s) begin
                                frame_err_cnt <= frame_err_cnt + CNT_WIDTH'(1);
                            end else begin
                                frame_ok_cnt  <= frame_ok_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            frame_err_cnt <= frame_err_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Bench for eth_rx_framer: directed and random frames compared cycle by cycle against a frame-level model.
module tb_eth_rx_framer;
    localparam int MAXC = 4096;
    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;

    eth_rx_framer_if mac();

    eth_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .mac(mac), .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    // stimulus, one entry per clock; index j is sampled at rising edge j
    bit         s_dv [MAXC];
    bit         s_er [MAXC];
    logic [7:0] s_d  [MAXC];
    int         n_stim;
    int         rst_at;
    int         mark_idx;

    // expected outputs observable just after rising edge j
    bit         e_valid [MAXC];
    bit         e_last  [MAXC];
    bit         e_err   [MAXC];
    logic [7:0] e_data  [MAXC];
    int         e_ok    [MAXC];
    int         e_bad   [MAXC];
    int         d_ok    [MAXC];
    int         d_bad   [MAXC];

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;
    int cur_idx = 0;

    int         obs_valid;
    int         obs_first;
    int         obs_lasts;
    logic [7:0] obs_last_data;
    logic       obs_last_err;

    byte_q_t pl;

    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        repeat (8) r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // standard Ethernet FCS value (final inversion applied)
    function automatic logic [31:0] fcs_of(input byte_q_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_add(c, q[i]);
        return ~c;
    endfunction

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) $display("FAIL %s: got %0h, expected %0h", name, got, want);
        else passes++;
    endtask

    task automatic push(input bit dv, input bit er, input logic [7:0] d);
        if (n_stim < MAXC) begin
            s_dv[n_stim] = dv;
            s_er[n_stim] = er;
            s_d[n_stim]  = d;
            n_stim++;
        end
    endtask

    task automatic idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            if (noisy) push(1'b0, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)));
            else push(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic fill_inc(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // preamble + SFD + payload (optionally one byte forced to 0xFF) + FCS computed on the intended payload
    task automatic add_frame(input int pre_len, input int flip_idx, input int er_idx,
                             input bit bad_fcs, input bit noisy);
        logic [31:0] f;
        f = fcs_of(pl);
        if (bad_fcs) f = f ^ 32'h0000_0100;
        for (int i = 0; i < pre_len; i++) push(1'b1, noisy && ($urandom_range(0, 1) == 1), 8'h55);
        push(1'b1, noisy && ($urandom_range(0, 1) == 1), 8'hD5);
        if (mark_idx < 0) mark_idx = n_stim;
        foreach (pl[i]) push(1'b1, (i == er_idx), (i == flip_idx) ? 8'hFF : pl[i]);
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, f[8*k +: 8]);
    endtask

    task automatic begin_seg();
        n_stim = 0;
        rst_at = -1;
        mark_idx = -1;
    endtask

    // One rx_dv-high run [s, e]; the frame ends at e+1 only if that cycle lies inside the region.
    task automatic model_run(input int s, input int e, input bit has_eof);
        int p;
        int n;
        bit bad;
        byte_q_t body;
        logic [31:0] fcs_rx;
        if (s_d[s] != 8'h55) return;
        p = s;
        while (p <= e && s_d[p] == 8'h55) p++;
        if (p > e) return;
        if (s_d[p] != 8'hD5) return;
        n = e - p;
        for (int i = 0; i + 5 <= n - 1; i++) begin
            e_valid[p + 6 + i] = 1'b1;
            e_data[p + 6 + i]  = s_d[p + 1 + i];
        end
        if (!has_eof) return;
        if (n <= 4) begin
            d_bad[e + 1]++;
            return;
        end
        bad = (n < 64) || (n > 1518);
        for (int k = p + 1; k <= e; k++) if (s_er[k]) bad = 1'b1;
        for (int k = p + 1; k <= e - 4; k++) body.push_back(s_d[k]);
        fcs_rx = {s_d[e], s_d[e-1], s_d[e-2], s_d[e-3]};
        if (fcs_rx != fcs_of(body)) bad = 1'b1;
        e_valid[e + 1] = 1'b1;
        e_data[e + 1]  = s_d[e - 4];
        e_last[e + 1]  = 1'b1;
        e_err[e + 1]   = bad;
        if (bad) d_bad[e + 1]++;
        else d_ok[e + 1]++;
    endtask

    task automatic model_region(input int lo, input int hi);
        int j;
        int e;
        j = lo;
        while (j < hi) begin
            if (!s_dv[j]) begin
                j++;
            end else begin
                e = j;
                while (e + 1 < hi && s_dv[e + 1]) e++;
                model_run(j, e, (e + 1 < hi));
                j = e + 1;
            end
        end
    endtask

    task automatic build_expect();
        int ok;
        int bad;
        for (int j = 0; j < MAXC; j++) begin
            e_valid[j] = 1'b0; e_last[j] = 1'b0; e_err[j] = 1'b0; e_data[j] = 8'h00;
            d_ok[j] = 0; d_bad[j] = 0;
        end
        if (rst_at < 0) begin
            model_region(0, n_stim);
        end else begin
            model_region(0, rst_at);
            model_region(rst_at + 1, n_stim);
        end
        ok = 0;
        bad = 0;
        for (int j = 0; j < n_stim; j++) begin
            if (j == rst_at) begin
                ok = 0;
                bad = 0;
            end else begin
                ok += d_ok[j];
                bad += d_bad[j];
            end
            e_ok[j] = ok;
            e_bad[j] = bad;
        end
    endtask

    // single compare process: every cycle of a segment against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (mac.m_valid !== e_valid[cur_idx] ||
                (e_valid[cur_idx] && (mac.m_data !== e_data[cur_idx] || mac.m_last !== e_last[cur_idx] ||
                                      (e_last[cur_idx] && mac.m_err !== e_err[cur_idx]))) ||
                frame_ok_cnt !== 16'(e_ok[cur_idx]) || frame_err_cnt !== 16'(e_bad[cur_idx]))
                $display("FAIL stream[%0d]: got v=%b d=%h l=%b e=%b ok=%0d bad=%0d, expected v=%b d=%h l=%b e=%b ok=%0d bad=%0d",
                         cur_idx, mac.m_valid, mac.m_data, mac.m_last, mac.m_err, frame_ok_cnt, frame_err_cnt,
                         e_valid[cur_idx], e_data[cur_idx], e_last[cur_idx], e_err[cur_idx],
                         e_ok[cur_idx], e_bad[cur_idx]);
            else
                passes++;
            if (mac.m_valid === 1'b1) begin
                obs_valid++;
                if (obs_first < 0) obs_first = cur_idx;
                if (mac.m_last === 1'b1) begin
                    obs_lasts++;
                    obs_last_data = mac.m_data;
                    obs_last_err = mac.m_err;
                end
            end
        end
    end

    task automatic run_segment(input string name);
        build_expect();
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_lit({name, "/reset_state"},
                  {mac.m_data, mac.m_valid, mac.m_last, mac.m_err, frame_ok_cnt, frame_err_cnt}, 32'h0);
        rst_n = 1'b1;
        obs_valid = 0; obs_first = -1; obs_lasts = 0; obs_last_data = 8'h00; obs_last_err = 1'b0;
        for (int j = 0; j < n_stim; j++) begin
            rx_dv = s_dv[j]; rx_er = s_er[j]; rxd = s_d[j];
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_lit({name, "/async_reset"},
                          {mac.m_data, mac.m_valid, mac.m_last, mac.m_err, frame_ok_cnt, frame_err_cnt}, 32'h0);
            end
            @(posedge clk);
            #1;
            cur_idx = j;
            chk_en = 1'b1;
            @(negedge clk);
            if (j == rst_at) rst_n = 1'b1;
        end
        #1;
        chk_en = 1'b0;
    endtask

    initial begin
        byte_q_t q9;
        int len;
        int kind;
        q9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check_lit("crc_pin", fcs_of(q9), 32'hCBF43926);

        begin_seg(); fill_inc(60); add_frame(7, -1, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("good");
        check_lit("good/valid_count", obs_valid, 60);
        check_lit("good/latency", obs_first - mark_idx + 1, 6);
        check_lit("good/last_data", obs_last_data, 8'h3B);
        check_lit("good/last_err", obs_last_err, 0);
        check_lit("good/last_pulses", obs_lasts, 1);
        check_lit("good/ok_cnt", frame_ok_cnt, 1);

        begin_seg(); fill_inc(60); add_frame(7, 10, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("bad_fcs");
        check_lit("bad_fcs/valid_count", obs_valid, 60);
        check_lit("bad_fcs/last_err", obs_last_err, 1);
        check_lit("bad_fcs/err_cnt", frame_err_cnt, 1);

        begin_seg(); fill_inc(60); add_frame(7, -1, 20, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("rx_er");
        check_lit("rx_er/last_err", obs_last_err, 1);
        check_lit("rx_er/err_cnt", frame_err_cnt, 1);
        check_lit("rx_er/ok_cnt", frame_ok_cnt, 0);

        begin_seg(); fill_inc(20); add_frame(7, -1, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("runt20");
        check_lit("runt20/valid_count", obs_valid, 20);
        check_lit("runt20/last_err", obs_last_err, 1);

        begin_seg();
        for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 8'(i + 1));
        idle(8, 1'b0);
        run_segment("runt3");
        check_lit("runt3/valid_count", obs_valid, 0);
        check_lit("runt3/err_cnt", frame_err_cnt, 1);

        begin_seg();
        push(1'b1, 1'b0, 8'h55); push(1'b1, 1'b0, 8'h57);
        for (int i = 0; i < 70; i++) push(1'b1, 1'b0, 8'(i));
        idle(8, 1'b0);
        run_segment("pre_err");
        check_lit("pre_err/valid_count", obs_valid, 0);
        check_lit("pre_err/counters", {frame_ok_cnt, frame_err_cnt}, 0);

        begin_seg(); fill_inc(60);
        add_frame(7, -1, -1, 1'b0, 1'b0); idle(1, 1'b0); add_frame(7, -1, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("b2b");
        check_lit("b2b/valid_count", obs_valid, 120);
        check_lit("b2b/ok_cnt", frame_ok_cnt, 2);

        begin_seg(); fill_inc(60);
        add_frame(7, -1, -1, 1'b0, 1'b0); idle(2, 1'b0);
        mark_idx = -1;
        add_frame(7, -1, -1, 1'b0, 1'b0);
        rst_at = mark_idx + 30;
        idle(3, 1'b0); add_frame(7, -1, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("mid_reset");
        check_lit("mid_reset/ok_cnt", frame_ok_cnt, 1);
        check_lit("mid_reset/err_cnt", frame_err_cnt, 0);

        begin_seg();
        fill_rand(60);   add_frame(2, -1, -1, 1'b0, 1'b0); idle(1, 1'b0);
        fill_rand(59);   add_frame(2, -1, -1, 1'b0, 1'b0); idle(1, 1'b0);
        fill_rand(1514); add_frame(2, -1, -1, 1'b0, 1'b0); idle(1, 1'b0);
        fill_rand(1515); add_frame(2, -1, -1, 1'b0, 1'b0); idle(8, 1'b0);
        run_segment("bounds");
        check_lit("bounds/ok_cnt", frame_ok_cnt, 2);
        check_lit("bounds/err_cnt", frame_err_cnt, 2);
        check_lit("bounds/last_err", obs_last_err, 1);

        begin_seg();
        while (n_stim < 3300) begin
            kind = $urandom_range(0, 9);
            len = (kind < 3) ? $urandom_range(0, 8) : $urandom_range(40, 140);
            fill_rand(len);
            if (kind == 9) begin
                push(1'b1, 1'b0, 8'h55);
                push(1'b1, 1'b0, 8'h3C);
                for (int i = 0; i < len; i++) push(1'b1, 1'b0, pl[i]);
            end else begin
                add_frame($urandom_range(1, 8),
                          ($urandom_range(0, 4) == 0) ? $urandom_range(0, 140) : -1,
                          ($urandom_range(0, 4) == 0) ? $urandom_range(0, 140) : -1,
                          ($urandom_range(0, 5) == 0), 1'b1);
            end
            idle($urandom_range(1, 3), 1'b1);
        end
        idle(8, 1'b0);
        run_segment("random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
